// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one valid/ready memory slave port between two masters (round-robin or fixed priority).
// Defining MEM_ARB_TIMEOUT_EN adds a grant watchdog and the timeout_err output.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  input  logic                m0_instr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic                m1_instr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic                s_instr,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic                timeout_err,
`endif
  output logic                grant_id,
  output logic                busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                grant_id_q, grant_id_d;
  logic                sel;
  logic                o_valid, o_instr, o_ready;
  logic [ADDR_W-1:0]   o_addr;
  logic [DATA_W-1:0]   o_wdata, o_rdata;
  logic [DATA_W/8-1:0] o_wstrb;
  logic                tmo;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam int REP = (DATA_W + 31) / 32;
  localparam logic [REP*32-1:0] TMO_FULL = {REP{32'hDEADBEEF}};
  localparam logic [DATA_W-1:0] TMO_DATA = TMO_FULL[DATA_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_err = tmo;
`endif

  always_comb begin
    sel     = (state_q == GNT1);
    o_valid = sel ? m1_valid : m0_valid;
    o_instr = sel ? m1_instr : m0_instr;
    o_addr  = sel ? m1_addr  : m0_addr;
    o_wdata = sel ? m1_wdata : m0_wdata;
    o_wstrb = sel ? m1_wstrb : m0_wstrb;
    tmo     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    // Counter is held at zero in IDLE so every grant starts a fresh window.
    cnt_d = '0;
    if (state_q != IDLE) begin
      tmo   = o_valid && !s_ready && (cnt_q == CNT_MAX);
      cnt_d = s_ready ? cnt_q : cnt_q + CNT_W'(1);
    end
    o_rdata = tmo ? TMO_DATA : s_rdata;
`else
    o_rdata = s_rdata;
`endif
    o_ready = (s_ready && o_valid) || tmo;

    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    grant_id_d = grant_id_q;
    s_valid    = 1'b0;
    s_instr    = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_wstrb    = '0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    busy       = (state_q != IDLE);
    grant_id   = grant_id_q;

    case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          if (ARB_MODE == 0 && !last_gnt_q) begin
            state_d    = GNT1;
            grant_id_d = 1'b1;
          end else begin
            state_d    = GNT0;
            grant_id_d = 1'b0;
          end
        end else if (m0_valid) begin
          state_d    = GNT0;
          grant_id_d = 1'b0;
        end else if (m1_valid) begin
          state_d    = GNT1;
          grant_id_d = 1'b1;
        end
      end
      default: begin
        s_valid = o_valid && !tmo;
        s_instr = o_instr;
        s_addr  = o_addr;
        s_wdata = o_wdata;
        s_wstrb = o_wstrb;
        if (sel) begin
          m1_ready = o_ready;
          m1_rdata = o_rdata;
        end else begin
          m0_ready = o_ready;
          m0_rdata = o_rdata;
        end
        // A master dropping valid mid-grant releases the port without updating fairness.
        if (!o_valid) begin
          state_d = IDLE;
        end else if (s_ready || tmo) begin
          state_d    = IDLE;
          last_gnt_d = sel;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      grant_id_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      grant_id_q <= grant_id_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin and fixed-priority instances side by side, each checked
// every cycle against a transaction-level model; directed scenarios followed by random traffic.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          mv [2][2];
  logic          mi [2][2];
  logic [AW-1:0] ma [2][2];
  logic [DW-1:0] mw [2][2];
  logic [SW-1:0] ms [2][2];
  logic          mr [2][2];
  logic [DW-1:0] mrd[2][2];
  logic          sv [2];
  logic          si [2];
  logic [AW-1:0] sa [2];
  logic [DW-1:0] swd[2];
  logic [SW-1:0] ss [2];
  logic          sr [2];
  logic [DW-1:0] srd[2];
  logic          gid[2];
  logic          bsy[2];
`ifdef MEM_ARB_TIMEOUT_EN
  logic          terr[2];
`endif

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(k), .TIMEOUT_CYCLES(TMO)
    ) u_dut (
      .clk(clk), .reset(rst),
      .m0_valid(mv[k][0]), .m0_instr(mi[k][0]), .m0_addr(ma[k][0]), .m0_wdata(mw[k][0]),
      .m0_wstrb(ms[k][0]), .m0_ready(mr[k][0]), .m0_rdata(mrd[k][0]),
      .m1_valid(mv[k][1]), .m1_instr(mi[k][1]), .m1_addr(ma[k][1]), .m1_wdata(mw[k][1]),
      .m1_wstrb(ms[k][1]), .m1_ready(mr[k][1]), .m1_rdata(mrd[k][1]),
      .s_valid(sv[k]), .s_instr(si[k]), .s_addr(sa[k]), .s_wdata(swd[k]), .s_wstrb(ss[k]),
      .s_ready(sr[k]), .s_rdata(srd[k]),
`ifdef MEM_ARB_TIMEOUT_EN
      .timeout_err(terr[k]),
`endif
      .grant_id(gid[k]), .busy(bsy[k])
    );
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model: owner of the port (-1 = nobody), fairness memory, reported grant id, grant age.
  int   owner[2];
  logic last [2];
  logic egid [2];
  int   age  [2];
  logic exp_rdy[2][2];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic tmo_now(input int k);
`ifdef MEM_ARB_TIMEOUT_EN
    return owner[k] >= 0 && mv[k][owner[k]] && !sr[k] && age[k] == TMO - 1;
`else
    return (k < 0);
`endif
  endfunction

  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        owner[k] = -1; last[k] = 1'b1; egid[k] = 1'b0; age[k] = 0;
      end else if (owner[k] < 0) begin
        int w = -1;
        if (mv[k][0] && mv[k][1]) w = (k == 1) ? 0 : (last[k] ? 0 : 1);
        else if (mv[k][0]) w = 0;
        else if (mv[k][1]) w = 1;
        if (w >= 0) begin owner[k] = w; egid[k] = w[0]; age[k] = 0; end
      end else begin
        int o = owner[k];
        logic t = tmo_now(k);
        if (!mv[k][o]) owner[k] = -1;
        else if (sr[k] || t) begin last[k] = o[0]; owner[k] = -1; end
        else age[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int o = owner[k];
      logic t = tmo_now(k);
      logic ev, ei;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      logic [SW-1:0] es;
      if (o >= 0) begin
        ev = mv[k][o] & ~t; ei = mi[k][o]; ea = ma[k][o]; ew = mw[k][o]; es = ms[k][o];
      end else begin
        ev = 1'b0; ei = 1'b0; ea = '0; ew = '0; es = '0;
      end
      chk($sformatf("d%0d_s_valid", k), DW'(sv[k]), DW'(ev));
      chk($sformatf("d%0d_s_instr", k), DW'(si[k]), DW'(ei));
      chk($sformatf("d%0d_s_addr", k), sa[k], ea);
      chk($sformatf("d%0d_s_wdata", k), swd[k], ew);
      chk($sformatf("d%0d_s_wstrb", k), DW'(ss[k]), DW'(es));
      for (int x = 0; x < 2; x++) begin
        logic er = (o == x) && ((sr[k] && mv[k][x]) || t);
        logic [DW-1:0] ed = (o == x) ? (t ? 32'hDEADBEEF : srd[k]) : '0;
        exp_rdy[k][x] = er;
        chk($sformatf("d%0d_m%0d_ready", k, x), DW'(mr[k][x]), DW'(er));
        chk($sformatf("d%0d_m%0d_rdata", k, x), mrd[k][x], ed);
      end
      chk($sformatf("d%0d_grant_id", k), DW'(gid[k]), DW'(egid[k]));
      chk($sformatf("d%0d_busy", k), DW'(bsy[k]), DW'(o >= 0));
`ifdef MEM_ARB_TIMEOUT_EN
      chk($sformatf("d%0d_timeout_err", k), DW'(terr[k]), DW'(t));
`endif
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic chk_now();
    #1;
    check_all();
  endtask

  task automatic set_m(input int x, input logic v, input logic ins, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int k = 0; k < 2; k++) begin
      mv[k][x] = v; mi[k][x] = ins; ma[k][x] = a; mw[k][x] = d; ms[k][x] = s;
    end
  endtask

  task automatic set_s(input logic r, input logic [DW-1:0] d);
    for (int k = 0; k < 2; k++) begin sr[k] = r; srd[k] = d; end
  endtask

  task automatic flush();
    cyc();
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    set_s(1'b0, '0);
    chk_now();
    repeat (3) begin cyc(); chk_now(); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int   g[2][$];
    logic m1_seen;
    logic pend[2][2];
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; last[k] = 1'b1; egid[k] = 1'b0; age[k] = 0;
      pend[k][0] = 1'b0; pend[k][1] = 1'b0;
    end
    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    set_s(1'b0, '0);
    cyc(); chk_now();
    cyc(); chk_now();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy_d%0d", k), DW'(bsy[k]), '0);
      chk($sformatf("rst_gid_d%0d", k), DW'(gid[k]), '0);
      chk($sformatf("rst_svalid_d%0d", k), DW'(sv[k]), '0);
    end

    // m0 read at 0x530, slave answers two cycles after s_valid
    cyc(); rst = 1'b0; set_m(0, 1'b1, 1'b0, 32'h530, '0, '0); chk_now();
    chk("t1_idle_svalid", DW'(sv[0]), '0);
    cyc(); chk_now();
    chk("t1_svalid", DW'(sv[0]), 1);
    chk("t1_saddr", sa[0], 32'h530);
    cyc(); chk_now();
    chk("t1_no_ready_yet", DW'(mr[0][0]), '0);
    cyc(); set_s(1'b1, 32'h12345678); chk_now();
    chk("t1_m0_ready", DW'(mr[0][0]), 1);
    chk("t1_m0_rdata", mrd[0][0], 32'h12345678);
    chk("t1_m1_ready", DW'(mr[0][1]), '0);
    cyc(); set_m(0, 1'b0, 1'b0, '0, '0, '0); set_s(1'b0, '0); chk_now();
    chk("t1_back_idle", DW'(bsy[0]), '0);

    // both masters valid continuously, slave always ready
    cyc(); rst = 1'b1; chk_now();
    cyc(); rst = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h100, '0, '0);
    set_m(1, 1'b1, 1'b1, 32'h200, '0, '0);
    set_s(1'b1, 32'h55);
    chk_now();
    repeat (8) begin
      cyc(); chk_now();
      for (int k = 0; k < 2; k++) if (bsy[k]) g[k].push_back(int'(gid[k]));
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t2_ngrants_d%0d", k), DW'(g[k].size()), 4);
      for (int i = 0; i < 4 && i < g[k].size(); i++)
        chk($sformatf("t2_grant%0d_d%0d", i, k), DW'(g[k][i]), (k == 0) ? DW'(i % 2) : '0);
    end
    cyc(); set_m(0, 1'b0, 1'b0, '0, '0, '0); chk_now();
    m1_seen = 1'b0;
    repeat (4) begin
      cyc(); chk_now();
      if (bsy[1] && gid[1]) m1_seen = 1'b1;
    end
    chk("t2_m1_after_m0_drops", DW'(m1_seen), 1);
    flush();

    // m1 write arrives while m0 holds the grant
    cyc(); set_m(0, 1'b1, 1'b0, 32'h40, '0, '0); chk_now();
    cyc(); set_m(1, 1'b1, 1'b0, 32'h8000, 32'hA5A5A5A5, 4'hF); chk_now();
    chk("t3_gnt0_gid", DW'(gid[0]), '0);
    chk("t3_m1_wait_a", DW'(mr[0][1]), '0);
    chk("t3_saddr_m0", sa[0], 32'h40);
    cyc(); chk_now();
    chk("t3_m1_wait_b", DW'(mr[1][1]), '0);
    cyc(); set_s(1'b1, 32'h77); chk_now();
    chk("t3_m0_done", DW'(mr[0][0]), 1);
    chk("t3_m1_wait_c", DW'(mr[0][1]), '0);
    cyc(); set_m(0, 1'b0, 1'b0, '0, '0, '0); set_s(1'b0, '0); chk_now();
    chk("t3_gap_idle", DW'(bsy[0]), '0);
    cyc(); chk_now();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t3_gid_d%0d", k), DW'(gid[k]), 1);
      chk($sformatf("t3_saddr_d%0d", k), sa[k], 32'h8000);
      chk($sformatf("t3_swdata_d%0d", k), swd[k], 32'hA5A5A5A5);
      chk($sformatf("t3_swstrb_d%0d", k), DW'(ss[k]), 32'hF);
    end

    // reset in the middle of the m1 grant, then a simultaneous request
    cyc(); rst = 1'b1; set_m(0, 1'b1, 1'b0, 32'h10, '0, '0); chk_now();
    cyc(); rst = 1'b0; chk_now();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t4_svalid_d%0d", k), DW'(sv[k]), '0);
      chk($sformatf("t4_busy_d%0d", k), DW'(bsy[k]), '0);
      chk($sformatf("t4_gid_d%0d", k), DW'(gid[k]), '0);
    end
    cyc(); chk_now();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t4_regrant_busy_d%0d", k), DW'(bsy[k]), 1);
      chk($sformatf("t4_regrant_m0_d%0d", k), DW'(gid[k]), '0);
    end
    flush();

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int n_gnt = 0, at = -1, n_terr = 0;
      logic [DW-1:0] tdata = '0;
      cyc(); set_m(0, 1'b1, 1'b0, 32'h20, '0, '0); chk_now();
      repeat (12) begin
        cyc(); chk_now();
        if (bsy[0]) n_gnt++;
        if (terr[0]) n_terr++;
        if (mr[0][0] && at < 0) begin at = n_gnt; tdata = mrd[0][0]; set_m(0, 1'b0, 1'b0, '0, '0, '0); end
      end
      chk("t5_timeout_cycle", DW'(at), TMO);
      chk("t5_timeout_rdata", tdata, 32'hDEADBEEF);
      chk("t5_timeout_err_once", DW'(n_terr), 1);
      flush();
    end
`endif

    // random traffic, occasional abandoned requests and resets
    repeat (600) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        for (int x = 0; x < 2; x++) begin
          if (!pend[k][x] || exp_rdy[k][x]) begin
            mv[k][x] = ($urandom_range(0, 2) != 0);
            mi[k][x] = 1'($urandom_range(0, 1));
            ma[k][x] = $urandom;
            mw[k][x] = $urandom;
            ms[k][x] = 4'($urandom_range(0, 15));
            pend[k][x] = mv[k][x];
          end else if ($urandom_range(0, 31) == 0) begin
            mv[k][x] = 1'b0;
            pend[k][x] = 1'b0;
          end
        end
        sr[k]  = ($urandom_range(0, 9) < 4);
        srd[k] = $urandom;
      end
      rst = ($urandom_range(0, 199) == 0);
      chk_now();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares one native valid/ready memory port (the on-chip memory_module slave) between the picorv32 core bus (m0) and a second bus master such as an Ethernet DMA (m1).
- Sits between the core-side address mux and the memory module.
- Grants one transaction at a time and holds the grant until the slave's ready. Arbitration is round-robin by default, with a fixed-priority option.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; wstrb width = DATA_W/8.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with m0 highest.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature, must be ≥ 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_valid  in  1  core request valid.
- m0_instr  in  1  core instruction-fetch flag.
- m0_addr  in  ADDR_W  core address.
- m0_wdata  in  DATA_W  core write data.
- m0_wstrb  in  DATA_W/8  core byte strobes; 0 means read.
- m0_ready  out  1  core transaction complete.
- m0_rdata  out  DATA_W  core read data.
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0_*, for requester 1.
- s_valid  out  1  request to memory slave.
- s_instr  out  1  forwarded instr flag.
- s_addr  out  ADDR_W  forwarded address.
- s_wdata  out  DATA_W  forwarded write data.
- s_wstrb  out  DATA_W/8  forwarded strobes.
- s_ready  in  1  slave completion.
- s_rdata  in  DATA_W  slave read data.
- grant_id  out  1  index of the current or last granted requester.
- busy  out  1  high in either grant state.

Behaviour:
- States: IDLE, GNT0, GNT1. Registers: state, last_gnt (1 bit), and the watchdog counter when the optional feature is enabled.
- Reset (synchronous, takes effect even mid-transaction):
  - state = IDLE, last_gnt = 1, so m0 wins the first tie.
  - s_valid, m0_ready, m1_ready, busy and grant_id = 0.
  - s_addr, s_wdata, s_wstrb, s_instr = 0.
  - m0_rdata and m1_rdata = 0.
- IDLE:
  - s_valid = 0 and both m*_ready = 0.
  - Only m0_valid: go to GNT0. Only m1_valid: go to GNT1. Neither: stay in IDLE.
  - Both valid, ARB_MODE=0: grant the requester that is not last_gnt.
  - Both valid, ARB_MODE=1: grant m0.
- GNTx:
  - s_* = mx_* combinationally, with s_valid = mx_valid.
  - mx_ready = s_ready; mx_rdata = s_rdata.
  - The other requester sees ready = 0 and rdata = 0.
  - On s_ready && mx_valid: next state IDLE, last_gnt = x.
  - If mx_valid drops before s_ready (protocol violation): next state IDLE, last_gnt unchanged, no ready pulse issued.
- Latency:
  - Request at cycle N in IDLE → s_valid at N+1 → mx_ready in the same cycle as s_ready.
  - Minimum gap is one IDLE cycle between consecutive grants, so back-to-back traffic from two requesters alternates at ≥ 2 cycles per transaction.
- No starvation in ARB_MODE=0: a pending requester waits at most one foreign transaction.
- ARB_MODE=1: m1 may starve by design.
- grant_id updates on entry to GNTx and holds through IDLE. busy = (state != IDLE).
- A requester's valid arriving while the other holds the grant is ignored until the next IDLE cycle. The arbiter never aborts a granted transaction.
- s_ready seen in IDLE is ignored.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to GNTx and increments each cycle in GNTx without s_ready.
  - When the counter reaches TIMEOUT_CYCLES-1 without s_ready, the arbiter forces mx_ready = 1 with mx_rdata = 32'hDEADBEEF (pattern replicated/truncated to DATA_W).
  - s_valid is deasserted that cycle; next state IDLE, last_gnt = x.
  - A one-cycle pulse on extra output port timeout_err (out, 1; reset 0) is emitted.
  - s_ready and the timeout in the same cycle: s_ready wins, no error.
- When undefined: no counter, no timeout_err port, and a grant waits indefinitely.

Test Plan:
- Reset, then m0 read at addr 0x530 with the slave answering ready two cycles after s_valid with 0x12345678 → s_valid one cycle after m0_valid, m0_ready in the same cycle as s_ready, m0_rdata = 0x12345678, m1_ready stays 0.
- m0 and m1 both valid continuously, ARB_MODE=0, slave ready after one cycle → grants alternate m0, m1, m0, m1, with grant_id tracking and one IDLE cycle between grants.
- Same stimulus with ARB_MODE=1 → only m0 is granted while m0_valid stays high; m1 is granted once m0_valid drops.
- m1 write (addr 0x8000, wdata 0xA5A5A5A5, wstrb 0xF) during an m0 grant → m1 receives no ready until m0 completes; the slave then sees the m1 fields exactly.
- reset asserted mid GNT1 → next cycle s_valid = 0, busy = 0, grant_id = 0; a subsequent simultaneous request is granted to m0.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and a slave that never responds → m0_ready pulses with rdata 0xDEADBEEF after 8 grant cycles, timeout_err pulses once, state returns to IDLE.
